// File: rtl/int_ctrl_nested.sv
// int_ctrl_nested: N-channel edge-triggered interrupt controller
// with fixed priority, nesting via in-service register, PC mux drive.
module int_ctrl_nested #(
  parameter int N_CH = 4,
  parameter int VEC_W = 32,
  parameter logic [VEC_W-1:0] VEC_BASE = VEC_W'(32'h0000_0018),
  parameter int VEC_STRIDE = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_CH-1:0]           ex_req,
  input  logic [N_CH-1:0]           mask,
  input  logic                      gie,
  input  logic                      ret,
  output logic                      int_any,
  output logic [N_CH-1:0]           inta,
  output logic [1:0]                pc_s,
  output logic                      write_pc,
  output logic [VEC_W-1:0]          int_vector,
  output logic [N_CH-1:0]           in_service,
  output logic [$clog2(N_CH)-1:0]   cur_id,
  output logic [N_CH-1:0]           overrun
);

  localparam int IW = $clog2(N_CH);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_ACK  = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nx;

  logic [N_CH-1:0]   r_ex_q;
  logic [N_CH-1:0]   r_pend;
  logic [N_CH-1:0]   r_isv;
  logic [N_CH-1:0]   r_inta;
  logic [N_CH-1:0]   r_ovr;
  logic              r_int_any;
  logic              r_wpc;
  logic [1:0]        r_pc_s;
  logic [VEC_W-1:0]  r_vec;

  logic [N_CH-1:0]   w_rise;
  logic [N_CH-1:0]   w_is_low;
  logic [N_CH-1:0]   w_allow;
  logic [N_CH-1:0]   w_elig;
  logic [N_CH-1:0]   w_ack_oh;
  logic [N_CH-1:0]   w_ret_clr;
  logic [N_CH-1:0]   w_pend_nx;
  logic [N_CH-1:0]   w_isv_nx;
  logic [N_CH-1:0]   w_ovr_nx;
  logic              w_ack_go;
  logic [IW-1:0]     w_ack_idx;
  logic [IW-1:0]     w_cur_id;
  logic [VEC_W-1:0]  w_vec;

  // Request qualification: edges, priority window below current level
  always_comb begin
    w_rise    = ex_req & ~r_ex_q;
    w_is_low  = r_isv & (~r_isv + N_CH'(1));
    w_allow   = (r_isv == '0) ? '1 : (w_is_low - N_CH'(1));
    w_elig    = r_pend & ~mask & {N_CH{gie}} & w_allow;
    w_ret_clr = ret ? w_is_low : '0;
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nx;
  end

  // FSM next state: acknowledge holds for exactly one cycle
  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      S_IDLE: if (|w_elig) w_state_nx = S_ACK;
      S_ACK:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  // FSM outputs: pick the lowest eligible channel when idle
  always_comb begin
    w_ack_go = 1'b0;
    w_ack_oh = '0;
    unique case (r_state)
      S_IDLE: begin
        w_ack_go = |w_elig;
        w_ack_oh = w_elig & (~w_elig + N_CH'(1));
      end
      S_ACK: begin
        w_ack_go = 1'b0;
        w_ack_oh = '0;
      end
      default: begin
        w_ack_go = 1'b0;
        w_ack_oh = '0;
      end
    endcase
  end

  // Index and vector address of the acknowledged channel
  always_comb begin
    w_ack_idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (w_ack_oh[i]) w_ack_idx = IW'(i);
    end
    w_vec = VEC_BASE + VEC_W'(w_ack_idx) * VEC_W'(VEC_STRIDE);
  end

  // Next pending / in-service; a fresh rise re-arms an acked channel
  always_comb begin
    w_pend_nx = (r_pend & ~w_ack_oh) | w_rise;
    w_isv_nx  = (r_isv & ~w_ret_clr) | w_ack_oh;
    w_ovr_nx  = w_rise & r_pend & ~w_ack_oh;
  end

  // Controller state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex_q    <= '0;
      r_pend    <= '0;
      r_isv     <= '0;
      r_inta    <= '0;
      r_ovr     <= '0;
      r_int_any <= 1'b0;
      r_wpc     <= 1'b0;
      r_pc_s    <= 2'b00;
      r_vec     <= '0;
    end else begin
      r_ex_q    <= ex_req;
      r_pend    <= w_pend_nx;
      r_isv     <= w_isv_nx;
      r_inta    <= w_ack_oh;
      r_ovr     <= w_ovr_nx;
      r_int_any <= |w_elig;
      r_wpc     <= w_ack_go;
      r_pc_s    <= w_ack_go ? 2'b11 : 2'b00;
      if (w_ack_go) r_vec <= w_vec;
    end
  end

  // Current level: lowest in-service index, 0 when none
  always_comb begin
    w_cur_id = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (r_isv[i]) w_cur_id = IW'(i);
    end
  end

  assign int_any    = r_int_any;
  assign inta       = r_inta;
  assign pc_s       = r_pc_s;
  assign write_pc   = r_wpc;
  assign int_vector = r_vec;
  assign in_service = r_isv;
  assign cur_id     = w_cur_id;
  assign overrun    = r_ovr;

endmodule

// File: tb/tb_int_ctrl_nested.sv
// tb_int_ctrl_nested: scoreboard bench for int_ctrl_nested
// against a set-based reference model of the interrupt rules.
module tb_int_ctrl_nested;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  ex_req = '0;
  logic [N-1:0]  mask = '0;
  logic          gie = 1'b0;
  logic          ret = 1'b0;
  logic          int_any;
  logic [N-1:0]  inta;
  logic [1:0]    pc_s;
  logic          write_pc;
  logic [31:0]   int_vector;
  logic [N-1:0]  in_service;
  logic [1:0]    cur_id;
  logic [N-1:0]  overrun;

  always #5 clk = ~clk;

  int_ctrl_nested dut (
    .clk(clk), .rst(rst), .ex_req(ex_req), .mask(mask),
    .gie(gie), .ret(ret), .int_any(int_any), .inta(inta),
    .pc_s(pc_s), .write_pc(write_pc), .int_vector(int_vector),
    .in_service(in_service), .cur_id(cur_id), .overrun(overrun)
  );

  typedef struct {
    logic [N-1:0] inta;
    logic [31:0]  vec;
    logic [N-1:0] isv;
  } ack_t;

  typedef struct {
    logic         any;
    logic [N-1:0] ovr;
    logic [N-1:0] isv;
    logic [1:0]   cur;
    logic         busy;
    logic [31:0]  vec;
  } st_t;

  ack_t ackq[$];
  st_t  stq[$];
  int   checks = 0;
  int   passes = 0;

  bit         m_pend[N];
  bit         m_isv[N];
  bit         m_exq[N];
  bit         m_busy;
  logic [31:0] m_vec;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s actual=%h required=%h t=%0t",
                  nm, act, exp, $time);
  endtask

  function automatic int lowest_isv();
    for (int i = 0; i < N; i++) if (m_isv[i]) return i;
    return N;
  endfunction

  // Drive one cycle of inputs and predict what the next edge produces
  task automatic step(input logic [N-1:0] ex, input logic [N-1:0] mk,
                      input logic g, input logic rt, input logic rs);
    st_t  s;
    ack_t a;
    int   lo, w;
    bit   any;
    @(negedge clk);
    ex_req = ex; mask = mk; gie = g; ret = rt; rst = rs;
    s.ovr = '0;
    if (rs) begin
      for (int i = 0; i < N; i++) begin
        m_pend[i] = 0; m_isv[i] = 0; m_exq[i] = 0;
      end
      m_busy = 0; m_vec = 0; any = 0;
    end else begin
      lo = lowest_isv();
      w = N;
      any = 0;
      for (int i = 0; i < N; i++) begin
        if (m_pend[i] && !mk[i] && g && i < lo) begin
          any = 1;
          if (w == N) w = i;
        end
      end
      if (m_busy) w = N;
      for (int i = 0; i < N; i++) begin
        bit rise;
        rise = ex[i] && !m_exq[i];
        s.ovr[i] = rise && m_pend[i] && (i != w);
        if (i == w) m_pend[i] = 0;
        if (rise) m_pend[i] = 1;
        m_exq[i] = ex[i];
      end
      if (rt && lo < N) m_isv[lo] = 0;
      if (w < N) begin
        m_isv[w] = 1;
        m_vec = 32'h18 + 32'(w) * 4;
      end
      m_busy = (w < N);
      if (w < N) begin
        a.inta = '0;
        a.inta[w] = 1'b1;
        a.vec = m_vec;
        for (int i = 0; i < N; i++) a.isv[i] = m_isv[i];
        ackq.push_back(a);
      end
    end
    s.any  = any;
    s.busy = m_busy;
    s.vec  = m_vec;
    for (int i = 0; i < N; i++) s.isv[i] = m_isv[i];
    lo = lowest_isv();
    s.cur = (lo < N) ? 2'(lo) : 2'd0;
    stq.push_back(s);
  endtask

  task automatic hold(input int n);
    for (int k = 0; k < n; k++) step(ex_req, mask, gie, 1'b0, 1'b0);
  endtask

  task automatic rtn();
    step(ex_req, mask, gie, 1'b1, 1'b0);
  endtask

  // Monitor: per-cycle status plus acknowledge scoreboard
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (stq.size() != 0) begin
        st_t e;
        e = stq.pop_front();
        chk("int_any", 32'(int_any), 32'(e.any));
        chk("overrun", 32'(overrun), 32'(e.ovr));
        chk("in_service", 32'(in_service), 32'(e.isv));
        chk("cur_id", 32'(cur_id), 32'(e.cur));
        chk("write_pc", 32'(write_pc), 32'(e.busy));
        chk("pc_s", 32'(pc_s), e.busy ? 32'd3 : 32'd0);
        chk("int_vector", int_vector, e.vec);
        if (write_pc === 1'b1 || inta !== '0) begin
          if (ackq.size() == 0) begin
            checks++;
            $display("FAIL spurious_ack actual inta=%b required none",
                     inta);
          end else begin
            ack_t x;
            x = ackq.pop_front();
            chk("ack_inta", 32'(inta), 32'(x.inta));
            chk("ack_vector", int_vector, x.vec);
            chk("ack_isv", 32'(in_service), 32'(x.isv));
          end
        end
      end
    end
  end

  initial begin
    logic [N-1:0] ex, mk;
    step('0, '0, 1'b1, 1'b0, 1'b1);
    step('0, '0, 1'b1, 1'b0, 1'b1);
    hold(2);
    // single request on ch2
    step(4'b0100, '0, 1'b1, 1'b0, 1'b0);
    step('0, '0, 1'b1, 1'b0, 1'b0);
    hold(3);
    rtn(); hold(2);
    // simultaneous ch1 and ch3
    step(4'b1010, '0, 1'b1, 1'b0, 1'b0);
    step('0, '0, 1'b1, 1'b0, 1'b0);
    hold(4);
    rtn(); hold(4);
    rtn(); hold(2);
    // nesting: ch0 preempts ch2
    step(4'b0100, '0, 1'b1, 1'b0, 1'b0);
    step('0, '0, 1'b1, 1'b0, 1'b0);
    hold(2);
    step(4'b0001, '0, 1'b1, 1'b0, 1'b0);
    step('0, '0, 1'b1, 1'b0, 1'b0);
    hold(3);
    rtn(); hold(1);
    rtn(); hold(2);
    // masking, then unmask
    step(4'b0010, 4'b0010, 1'b1, 1'b0, 1'b0);
    step('0, 4'b0010, 1'b1, 1'b0, 1'b0);
    hold(3);
    step('0, '0, 1'b1, 1'b0, 1'b0);
    hold(3);
    rtn(); hold(1);
    // gie blocks
    step(4'b0001, '0, 1'b0, 1'b0, 1'b0);
    step('0, '0, 1'b0, 1'b0, 1'b0);
    hold(3);
    step('0, '0, 1'b1, 1'b0, 1'b0);
    hold(3);
    rtn(); hold(1);
    // overrun on masked ch2
    step(4'b0100, 4'b0100, 1'b1, 1'b0, 1'b0);
    step('0, 4'b0100, 1'b1, 1'b0, 1'b0);
    step(4'b0100, 4'b0100, 1'b1, 1'b0, 1'b0);
    step('0, 4'b0100, 1'b1, 1'b0, 1'b0);
    hold(2);
    step('0, '0, 1'b1, 1'b0, 1'b0);
    hold(5);
    rtn(); hold(1);
    // reset while inta is high
    step(4'b1000, '0, 1'b1, 1'b0, 1'b0);
    step('0, '0, 1'b1, 1'b0, 1'b0);
    step('0, '0, 1'b1, 1'b0, 1'b1);
    hold(4);
    // randomized traffic
    ex = '0; mk = '0;
    for (int k = 0; k < 3000; k++) begin
      logic g, rt, rs;
      ex = ex ^ (N'($urandom) & N'($urandom));
      if ($urandom_range(0, 7) == 0) mk = N'($urandom) & N'($urandom);
      g  = ($urandom_range(0, 9) != 0);
      rt = ($urandom_range(0, 4) == 0);
      rs = ($urandom_range(0, 199) == 0);
      step(ex, mk, g, rt, rs);
    end
    hold(3);
    @(posedge clk);
    #2;
    checks++;
    if (ackq.size() == 0) passes++;
    else $display("FAIL missing_ack actual pending=%0d required 0",
                  ackq.size());
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
